// File: rtl/risc_mc_controller.sv
// Multi-cycle control sequencer for the RISC-V core: walks each instruction through
// fetch/decode/execute/memory/writeback, drives datapath selects and strobes, counts retirements.
module risc_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       alu_ctrl,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t state, state_nx;
  logic   retire;

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_r,
                                            input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = 3'b000;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_nx = S_MEMADR;
          7'b0110011:             state_nx = S_EXECR;
          7'b0010011:             state_nx = S_EXECI;
          7'b1101111:             state_nx = S_JAL;
          7'b1100011:             state_nx = S_BEQ;
          default:                state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nx  = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_nx   = S_FETCH;
        retire     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_decode(funct3, 1'b1, funct7b5);
        state_nx  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_decode(funct3, 1'b0, funct7b5);
        state_nx  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
        retire    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nx  = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_ctrl  = 3'b001;
        pc_write  = zero;
        state_nx  = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
    // Reset kills every write/request strobe immediately, before the state register clears.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign trap    = (state == S_TRAP);
  assign state_o = state;

endmodule

// File: tb/tb_risc_mc_controller.sv
// Table-driven bench for risc_mc_controller: per-cycle vectors of inputs and expected outputs,
// plus a hand-written stalled lw sequence.
module tb_risc_mc_controller;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BQ = 7'b1100011, OP_JL = 7'b1101111,
                         OP_XX = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = OP_R;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, trap;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] instret;
  logic [3:0]  state_o;

  risc_mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .trap(trap), .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [51:0] exp;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   passed = 0;

  // exp packing: {state, pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
  //               alu_src_a, alu_src_b, result_src, alu_ctrl, trap, instret}
  task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic rdy, input logic [3:0] st, input logic [4:0] stb,
                     input logic adr, input logic [1:0] sa, input logic [1:0] sb,
                     input logic [1:0] rs, input logic [2:0] alu, input logic trp,
                     input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
    v.exp = {st, stb, adr, sa, sb, rs, alu, trp, cnt};
    vq.push_back(v);
  endtask

  function automatic logic [51:0] actual();
    return {state_o, pc_write, ir_write, mem_read, mem_write, reg_write, adr_src,
            alu_src_a, alu_src_b, result_src, alu_ctrl, trap, instret};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  initial begin
    int  cyc;
    bit  left;
    int  fstall, mstall;

    //  rst op    f3     f7 z  rdy  st  strobes  adr sa sb rs alu  trp cnt
    add(1, OP_R,  3'd0, 0, 0, 1,   0, 5'b00000, 0, 0, 2, 2, 3'd0, 0, 0);  // reset
    add(0, OP_R,  3'd0, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 0);  // add
    add(0, OP_R,  3'd0, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 0);
    add(0, OP_R,  3'd0, 0, 0, 1,   6, 5'b00000, 0, 2, 0, 0, 3'd0, 0, 0);
    add(0, OP_R,  3'd0, 0, 0, 1,   8, 5'b00001, 0, 0, 0, 0, 3'd0, 0, 0);
    add(0, OP_R,  3'd0, 1, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 1);  // sub
    add(0, OP_R,  3'd0, 1, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 1);
    add(0, OP_R,  3'd0, 1, 0, 1,   6, 5'b00000, 0, 2, 0, 0, 3'd1, 0, 1);
    add(0, OP_R,  3'd0, 1, 0, 1,   8, 5'b00001, 0, 0, 0, 0, 3'd0, 0, 1);
    add(0, OP_I,  3'd0, 1, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 2);  // addi, f7b5=1
    add(0, OP_I,  3'd0, 1, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 2);
    add(0, OP_I,  3'd0, 1, 0, 1,   7, 5'b00000, 0, 2, 1, 0, 3'd0, 0, 2);
    add(0, OP_I,  3'd0, 1, 0, 1,   8, 5'b00001, 0, 0, 0, 0, 3'd0, 0, 2);
    add(0, OP_I,  3'd7, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 3);  // andi
    add(0, OP_I,  3'd7, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 3);
    add(0, OP_I,  3'd7, 0, 0, 1,   7, 5'b00000, 0, 2, 1, 0, 3'd2, 0, 3);
    add(0, OP_I,  3'd7, 0, 0, 1,   8, 5'b00001, 0, 0, 0, 0, 3'd0, 0, 3);
    add(0, OP_LW, 3'd2, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 4);  // lw, 3 stalls
    add(0, OP_LW, 3'd2, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 4);
    add(0, OP_LW, 3'd2, 0, 0, 1,   2, 5'b00000, 0, 2, 1, 0, 3'd0, 0, 4);
    add(0, OP_LW, 3'd2, 0, 0, 0,   3, 5'b00100, 1, 0, 0, 0, 3'd0, 0, 4);
    add(0, OP_LW, 3'd2, 0, 0, 0,   3, 5'b00100, 1, 0, 0, 0, 3'd0, 0, 4);
    add(0, OP_LW, 3'd2, 0, 0, 0,   3, 5'b00100, 1, 0, 0, 0, 3'd0, 0, 4);
    add(0, OP_LW, 3'd2, 0, 0, 1,   3, 5'b00100, 1, 0, 0, 0, 3'd0, 0, 4);
    add(0, OP_LW, 3'd2, 0, 0, 1,   4, 5'b00001, 0, 0, 0, 1, 3'd0, 0, 4);
    add(0, OP_BQ, 3'd0, 0, 1, 0,   0, 5'b00100, 0, 0, 2, 2, 3'd0, 0, 5);  // fetch stall
    add(0, OP_BQ, 3'd0, 0, 1, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 5);  // beq taken
    add(0, OP_BQ, 3'd0, 0, 1, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 5);
    add(0, OP_BQ, 3'd0, 0, 1, 1,  10, 5'b10000, 0, 2, 0, 0, 3'd1, 0, 5);
    add(0, OP_BQ, 3'd0, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 6);  // beq not taken
    add(0, OP_BQ, 3'd0, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 6);
    add(0, OP_BQ, 3'd0, 0, 0, 1,  10, 5'b00000, 0, 2, 0, 0, 3'd1, 0, 6);
    add(0, OP_JL, 3'd0, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 7);  // jal
    add(0, OP_JL, 3'd0, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 7);
    add(0, OP_JL, 3'd0, 0, 0, 1,   9, 5'b10000, 0, 1, 2, 0, 3'd0, 0, 7);
    add(0, OP_JL, 3'd0, 0, 0, 1,   8, 5'b00001, 0, 0, 0, 0, 3'd0, 0, 7);
    add(0, OP_SW, 3'd2, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 8);  // sw, 1 stall
    add(0, OP_SW, 3'd2, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 8);
    add(0, OP_SW, 3'd2, 0, 0, 1,   2, 5'b00000, 0, 2, 1, 0, 3'd0, 0, 8);
    add(0, OP_SW, 3'd2, 0, 0, 0,   5, 5'b00010, 1, 0, 0, 0, 3'd0, 0, 8);
    add(0, OP_SW, 3'd2, 0, 0, 1,   5, 5'b00010, 1, 0, 0, 0, 3'd0, 0, 8);
    add(0, OP_SW, 3'd2, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 9);  // sw aborted
    add(0, OP_SW, 3'd2, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 9);
    add(0, OP_SW, 3'd2, 0, 0, 1,   2, 5'b00000, 0, 2, 1, 0, 3'd0, 0, 9);
    add(1, OP_SW, 3'd2, 0, 0, 1,   5, 5'b00000, 1, 0, 0, 0, 3'd0, 0, 9);
    add(1, OP_SW, 3'd2, 0, 0, 1,   0, 5'b00000, 0, 0, 2, 2, 3'd0, 0, 0);
    add(0, OP_XX, 3'd0, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 0);  // illegal
    add(0, OP_XX, 3'd0, 0, 0, 1,   1, 5'b00000, 0, 1, 1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 12; i++)
      add(0, OP_R, 3'd0, 0, 1, 1, 11, 5'b00000, 0, 0, 0, 0, 3'd0, 1, 0);
    add(1, OP_R,  3'd0, 0, 0, 1,  11, 5'b00000, 0, 0, 0, 0, 3'd0, 1, 0);
    add(0, OP_R,  3'd0, 0, 0, 1,   0, 5'b11100, 0, 0, 2, 2, 3'd0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; opcode = vq[i].op; funct3 = vq[i].f3;
      funct7b5 = vq[i].f7; zero = vq[i].z; mem_ready = vq[i].rdy;
      #1;
      check($sformatf("vec%0d", i), 64'(actual()), 64'(vq[i].exp));
    end

    // lw with 2 stall cycles in FETCH and 1 in MEMREAD: 5 + 3 = 8 cycles, one retirement.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; opcode = OP_LW; funct3 = 3'd2;
    cyc = 0; left = 1'b0; fstall = 2; mstall = 1;
    while (cyc < 50) begin
      if (state_o == 4'd0 && fstall > 0) begin mem_ready = 1'b0; fstall--; end
      else if (state_o == 4'd3 && mstall > 0) begin mem_ready = 1'b0; mstall--; end
      else mem_ready = 1'b1;
      cyc++;
      @(negedge clk);
      if (state_o != 4'd0) left = 1'b1;
      if (left && state_o == 4'd0) break;
    end
    check("lw_stall_cycles", 64'(cyc), 64'd8);
    check("lw_stall_instret", 64'(instret), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/risc_mc_controller.md
# risc_mc_controller

Multi-cycle control sequencer for the RISC-V core. It steps one instruction at a time through the shared-memory datapath (fetch, decode, execute, memory, writeback) and drives every datapath mux select and write strobe. It also stalls on a memory ready handshake, decodes the ALU operation, counts retired instructions, and traps on unsupported opcodes. It sits beside the datapath inside the `RISC` top, fed by the instruction register and the ALU zero flag.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC register load.
- `ir_write`  out  1  instruction/old-PC register load.
- `adr_src`  out  1  memory address: 0 = PC, 1 = result.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  2  00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- `result_src`  out  2  00 = ALU out register, 01 = memory data, 10 = ALU result direct.
- `alu_ctrl`  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `trap`  out  1  illegal opcode; sticky until reset.
- `instret`  out  CNT_W  retired-instruction count.
- `state_o`  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, JAL 9, BEQ 10, TRAP 11.
- All outputs are decoded from the state register only, except where gated by `mem_ready` or `zero`. Any output not listed for a state is 0 (alu_ctrl = add).
- FETCH: adr_src = 0, mem_read = 1, src_a = 00, src_b = 10, result_src = 10.
  - ir_write and pc_write are asserted only when mem_ready = 1.
  - Goes to DECODE when mem_ready = 1; otherwise holds.
- DECODE: src_a = 01, src_b = 01 (branch target computed). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → TRAP
- MEMADR: src_a = 10, src_b = 01. Goes to MEMREAD if opcode[5] = 0, otherwise MEMWRITE.
- MEMREAD: adr_src = 1, mem_read = 1. Goes to MEMWB on mem_ready.
- MEMWRITE: adr_src = 1, mem_write = 1. Goes to FETCH on mem_ready; the instruction retires.
- MEMWB: result_src = 01, reg_write = 1. Goes to FETCH; the instruction retires.
- EXECR: src_a = 10, src_b = 00, ALU decoded. Goes to ALUWB.
- EXECI: src_a = 10, src_b = 01, ALU decoded. Goes to ALUWB.
- ALUWB: reg_write = 1, result_src = 00. Goes to FETCH; the instruction retires.
- JAL: src_a = 01, src_b = 10, result_src = 00, pc_write = 1. Goes to ALUWB.
- BEQ: src_a = 10, src_b = 00, alu_ctrl = sub, result_src = 00, pc_write = zero. Goes to FETCH; the instruction retires.
- TRAP: trap = 1, all strobes 0. Stays in TRAP until reset.
- ALU decode (EXECR/EXECI), by funct3:
  - 000 → sub if (EXECR and funct7b5), else add
  - 010 → slt
  - 110 → or
  - 111 → and
  - others → add
- instret increments by 1 on each retiring transition and wraps modulo 2^CNT_W.

## Timing
- Reset sampled high at a clk edge:
  - state ← FETCH, instret ← 0, trap ← 0.
  - While reset is high, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0 combinationally.
- Reset mid-instruction aborts the instruction; no writeback occurs and instret is not incremented.
- Cycles per instruction with mem_ready tied to 1:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. During the stall, all outputs remain stable.
- Handshake: a request stays asserted until the cycle in which mem_ready = 1. Exactly one access completes per request.
- instret updates on the same edge as the return to FETCH.

## Test plan
- Reset held for 1 cycle, then an R-type add (opcode 0110011, funct3 000, funct7b5 0), mem_ready = 1 → states 0, 1, 6, 8, 0; reg_write high only in state 8; instret = 1.
- R-type sub (funct7b5 = 1) → alu_ctrl = 001 in EXECR. I-type (0010011) with funct7b5 = 1 → alu_ctrl = 000.
- lw with mem_ready low for 3 cycles in MEMREAD → mem_read and adr_src = 1 held for 4 cycles; 8 cycles total; result_src = 01 in MEMWB.
- beq with zero = 1, then zero = 0 → pc_write = 1 and 0 respectively in state 10; both take 3 cycles.
- Opcode 0000000 → TRAP; trap = 1 and all strobes 0 for 10+ cycles; reset returns to FETCH with trap = 0.
- Reset asserted during MEMWRITE → mem_write drops in the same cycle; state 0 next cycle; instret unchanged from 0.
